// File: rtl/load_select_pkg.sv
// Shared load/store address map, FSM state and decode-target types for the MEM stage.
// The optional Ethernet wait timeout is enabled with the LOAD_SELECT_TIMEOUT_EN macro.
package load_select_pkg;

   // Load-side peripheral offsets (addr[11:0], only meaningful with addr[11]=1)
   localparam logic [11:0] ADDR_SW     = 12'h808;
   localparam logic [11:0] ADDR_TIMER  = 12'h810;
   localparam logic [11:0] ADDR_ETH_RX = 12'h820;

   // Store-side targets; these read back as unmapped on the load path
   localparam logic [11:0] ADDR_LED    = 12'h804;
   localparam logic [11:0] ADDR_ETH_TX = 12'h824;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_DMEM_WAIT = 2'd1,
      ST_ETH_WAIT  = 2'd2,
      ST_RESP      = 2'd3
   } ls_state_t;

   typedef enum logic [2:0] {
      TGT_DMEM     = 3'd0,
      TGT_SW       = 3'd1,
      TGT_TIMER    = 3'd2,
      TGT_ETH      = 3'd3,
      TGT_UNMAPPED = 3'd4
   } ls_target_t;

   function automatic ls_target_t decode_load(input logic [31:0] a);
      ls_target_t t;
      if (a[11] == 1'b0) begin
         t = TGT_DMEM;
      end else begin
         case (a[11:0])
            ADDR_SW:     t = TGT_SW;
            ADDR_TIMER:  t = TGT_TIMER;
            ADDR_ETH_RX: t = TGT_ETH;
            default:     t = TGT_UNMAPPED;
         endcase
      end
      return t;
   endfunction

endpackage

// File: rtl/ls_timeout_ctr.sv
// Clear/enable/expire cycle counter bounding the Ethernet receive wait.
// expire is high in the LIMIT-th consecutive enabled cycle after a clear.
module ls_timeout_ctr #(
   parameter int LIMIT = 255
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic expire
);

   localparam int W = (LIMIT < 2) ? 1 : $clog2(LIMIT);
   localparam logic [W-1:0] LAST = W'(LIMIT - 1);

   logic [W-1:0] cnt_r;

   // Count enabled cycles, saturating at the expiry value
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_r <= {W{1'b0}};
      end else if (clr) begin
         cnt_r <= {W{1'b0}};
      end else if (en && (cnt_r != LAST)) begin
         cnt_r <= cnt_r + {{(W-1){1'b0}}, 1'b1};
      end else begin
         cnt_r <= cnt_r;
      end
   end

   assign expire = en && (cnt_r == LAST);

endmodule

// File: rtl/load_select.sv
// MEM-stage load selector: decodes the address, returns DMEM/peripheral data and stalls until ready.
// Define LOAD_SELECT_TIMEOUT_EN to bound the Ethernet wait to TIMEOUT_CYCLES cycles.
module load_select
   import load_select_pkg::*;
#(
   parameter int          TIMEOUT_CYCLES = 255,
   parameter logic [31:0] ERR_DATA       = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        re,
   input  logic [31:0] addr,
   input  logic [31:0] dmem_rdata,
   input  logic [15:0] sw_rdata,
   input  logic [31:0] timer_rdata,
   output logic        eth_req,
   input  logic        eth_ack,
   input  logic [31:0] eth_rdata,
   output logic [31:0] rdata,
   output logic        rvalid,
   output logic        stall,
   output logic        err
);

   ls_state_t   state_r, state_s;
   ls_target_t  tgt_s;
   logic [31:0] rdata_r, rdata_s;
   logic        rvalid_r, rvalid_s;
   logic        err_r, err_s;
   logic        eth_req_r;
   logic        ctr_clr_s;
   logic        timeout_s;

`ifdef LOAD_SELECT_TIMEOUT_EN
   ls_timeout_ctr #(
      .LIMIT (TIMEOUT_CYCLES)
   ) u_timeout (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr    (ctr_clr_s),
      .en     (state_r == ST_ETH_WAIT),
      .expire (timeout_s)
   );
`else
   assign timeout_s = 1'b0;
`endif

   assign tgt_s = decode_load(addr);

   // Next state and next registered response; rvalid_s marks entry into RESP
   always_comb begin
      state_s   = state_r;
      rdata_s   = rdata_r;
      rvalid_s  = 1'b0;
      err_s     = 1'b0;
      ctr_clr_s = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (re) begin
               case (tgt_s)
                  TGT_DMEM: begin
                     state_s = ST_DMEM_WAIT;
                  end
                  TGT_ETH: begin
                     state_s   = ST_ETH_WAIT;
                     ctr_clr_s = 1'b1;
                  end
                  TGT_SW: begin
                     rdata_s  = {16'h0000, sw_rdata};
                     rvalid_s = 1'b1;
                     state_s  = ST_RESP;
                  end
                  TGT_TIMER: begin
                     rdata_s  = timer_rdata;
                     rvalid_s = 1'b1;
                     state_s  = ST_RESP;
                  end
                  default: begin
                     rdata_s  = ERR_DATA;
                     err_s    = 1'b1;
                     rvalid_s = 1'b1;
                     state_s  = ST_RESP;
                  end
               endcase
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_DMEM_WAIT: begin
            rdata_s  = dmem_rdata;
            rvalid_s = 1'b1;
            state_s  = ST_RESP;
         end
         ST_ETH_WAIT: begin
            // An ack in the expiry cycle still delivers its data
            if (eth_ack) begin
               rdata_s  = eth_rdata;
               rvalid_s = 1'b1;
               state_s  = ST_RESP;
            end else if (timeout_s) begin
               rdata_s  = ERR_DATA;
               err_s    = 1'b1;
               rvalid_s = 1'b1;
               state_s  = ST_RESP;
            end else begin
               state_s = ST_ETH_WAIT;
            end
         end
         ST_RESP: begin
            state_s = ST_IDLE;
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase
   end

   // State and registered outputs; reset discards any in-flight load
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r   <= ST_IDLE;
         rdata_r   <= 32'h0000_0000;
         rvalid_r  <= 1'b0;
         err_r     <= 1'b0;
         eth_req_r <= 1'b0;
      end else begin
         state_r   <= state_s;
         rdata_r   <= rdata_s;
         rvalid_r  <= rvalid_s;
         err_r     <= err_s;
         eth_req_r <= (state_s == ST_ETH_WAIT);
      end
   end

   assign rdata   = rdata_r;
   assign rvalid  = rvalid_r;
   assign err     = err_r;
   assign eth_req = eth_req_r;

   // Low in RESP so the load retires; masked during reset so a held re does not freeze the pipe
   assign stall = rst_n && (((state_r == ST_IDLE) && re) ||
                            (state_r == ST_DMEM_WAIT) ||
                            (state_r == ST_ETH_WAIT));

endmodule

// File: tb/tb_load_select.sv
// Scoreboard bench for load_select: expected responses are queued at request time and
// matched against each rvalid pulse; handshake timing is checked cycle by cycle.
module tb_load_select;

   localparam int          TO       = 4;
   localparam logic [31:0] ERR_DATA = 32'h0000_0000;
   localparam logic [31:0] JUNK     = 32'hDEAD_BEEF;

   typedef struct packed {
      logic [31:0] data;
      logic        err;
   } exp_t;

   logic        clk;
   logic        rst_n;
   logic        re;
   logic [31:0] addr;
   logic [31:0] dmem_rdata;
   logic [15:0] sw_rdata;
   logic [31:0] timer_rdata;
   logic        eth_req;
   logic        eth_ack;
   logic [31:0] eth_rdata;
   logic [31:0] rdata;
   logic        rvalid;
   logic        stall;
   logic        err;

   int   checks = 0;
   int   errors = 0;
   exp_t sb_q[$];

   load_select #(
      .TIMEOUT_CYCLES (TO),
      .ERR_DATA       (ERR_DATA)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .re          (re),
      .addr        (addr),
      .dmem_rdata  (dmem_rdata),
      .sw_rdata    (sw_rdata),
      .timer_rdata (timer_rdata),
      .eth_req     (eth_req),
      .eth_ack     (eth_ack),
      .eth_rdata   (eth_rdata),
      .rdata       (rdata),
      .rvalid      (rvalid),
      .stall       (stall),
      .err         (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   // Response monitor: every rvalid pulse must match the oldest queued expectation
   always @(posedge clk) begin
      #1;
      if (rvalid) begin
         if (sb_q.size() == 0) begin
            check("spurious_rvalid", {31'h0, rvalid}, 32'h0);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            check("sb_rdata", rdata, e.data);
            check("sb_err", {31'h0, err}, {31'h0, e.err});
         end
      end else if (err) begin
         check("err_without_rvalid", {31'h0, err}, 32'h0);
      end
   end

   task automatic load_fast(input logic [31:0] a, input logic [31:0] d, input logic e);
      @(negedge clk);
      re = 1'b1; addr = a;
      sb_q.push_back('{data: d, err: e});
      #1;
      check("fast_stall_T", {31'h0, stall}, 32'h1);
      check("fast_rvalid_T", {31'h0, rvalid}, 32'h0);
      @(negedge clk);
      re = 1'b0;
      #1;
      check("fast_rvalid_T1", {31'h0, rvalid}, 32'h1);
      check("fast_stall_T1", {31'h0, stall}, 32'h0);
      check("fast_err_T1", {31'h0, err}, {31'h0, e});
      @(negedge clk);
      #1;
      check("fast_rvalid_T2", {31'h0, rvalid}, 32'h0);
   endtask

   task automatic dmem_load(input logic [31:0] a, input logic [31:0] d);
      @(negedge clk);
      re = 1'b1; addr = a; dmem_rdata = JUNK;
      sb_q.push_back('{data: d, err: 1'b0});
      #1;
      check("dmem_stall_T", {31'h0, stall}, 32'h1);
      @(negedge clk);
      addr = 32'h0000_0808; dmem_rdata = d;   // re held high: must be ignored here
      #1;
      check("dmem_stall_T1", {31'h0, stall}, 32'h1);
      check("dmem_rvalid_T1", {31'h0, rvalid}, 32'h0);
      @(negedge clk);
      re = 1'b0; dmem_rdata = JUNK;
      #1;
      check("dmem_rvalid_T2", {31'h0, rvalid}, 32'h1);
      check("dmem_stall_T2", {31'h0, stall}, 32'h0);
      @(negedge clk);
      #1;
      check("dmem_rvalid_T3", {31'h0, rvalid}, 32'h0);
   endtask

   task automatic eth_load(input int n, input logic [31:0] d);
      @(negedge clk);
      re = 1'b1; addr = 32'h0000_0820; eth_rdata = JUNK;
      sb_q.push_back('{data: d, err: 1'b0});
      #1;
      check("eth_stall_T", {31'h0, stall}, 32'h1);
      check("eth_req_T", {31'h0, eth_req}, 32'h0);
      for (int i = 1; i <= n; i++) begin
         @(negedge clk);
         re = 1'b0;
         if (i == n) begin
            eth_ack = 1'b1; eth_rdata = d;
         end else begin
            eth_rdata = JUNK;
         end
         #1;
         check("eth_req_wait", {31'h0, eth_req}, 32'h1);
         check("eth_stall_wait", {31'h0, stall}, 32'h1);
         check("eth_rvalid_wait", {31'h0, rvalid}, 32'h0);
      end
      @(negedge clk);
      eth_ack = 1'b0; eth_rdata = JUNK;
      #1;
      check("eth_rvalid_resp", {31'h0, rvalid}, 32'h1);
      check("eth_req_resp", {31'h0, eth_req}, 32'h0);
      check("eth_stall_resp", {31'h0, stall}, 32'h0);
      check("eth_err_resp", {31'h0, err}, 32'h0);
      @(negedge clk);
   endtask

   initial begin
      rst_n = 1'b0; re = 1'b1; addr = 32'h0000_0808;
      dmem_rdata = JUNK; sw_rdata = 16'h1111; timer_rdata = 32'h0;
      eth_ack = 1'b0; eth_rdata = JUNK;
      repeat (3) @(negedge clk);
      #1;
      check("rst_rdata", rdata, 32'h0);
      check("rst_rvalid", {31'h0, rvalid}, 32'h0);
      check("rst_stall", {31'h0, stall}, 32'h0);
      check("rst_eth_req", {31'h0, eth_req}, 32'h0);
      check("rst_err", {31'h0, err}, 32'h0);
      @(negedge clk);
      rst_n = 1'b1; re = 1'b0;
      @(negedge clk);

      dmem_load(32'h0000_0040, 32'h1234_5678);
      dmem_load(32'h0000_07FC, 32'h8765_4321);
      dmem_load(32'hFFFF_F7F0, 32'h0F0F_A0A0);

      sw_rdata = 16'hA5A5;
      load_fast(32'h0000_0808, 32'h0000_A5A5, 1'b0);
      timer_rdata = 32'h0BAD_F00D;
      load_fast(32'h0000_0810, 32'h0BAD_F00D, 1'b0);
      load_fast(32'h0000_08FC, ERR_DATA, 1'b1);
      sw_rdata = 16'hFFFF;
      load_fast(32'h1234_5808, 32'h0000_FFFF, 1'b0);
      load_fast(32'h0000_0804, ERR_DATA, 1'b1);
      load_fast(32'h0000_0C20, ERR_DATA, 1'b1);

      // re held through RESP: ignored there, accepted in the following IDLE
      @(negedge clk);
      sw_rdata = 16'h5A5A; timer_rdata = 32'h7777_0001;
      re = 1'b1; addr = 32'h0000_0808;
      sb_q.push_back('{data: 32'h0000_5A5A, err: 1'b0});
      @(negedge clk);
      addr = 32'h0000_0810;
      #1;
      check("b2b_rvalid_1", {31'h0, rvalid}, 32'h1);
      check("b2b_stall_resp", {31'h0, stall}, 32'h0);
      @(negedge clk);
      sb_q.push_back('{data: 32'h7777_0001, err: 1'b0});
      #1;
      check("b2b_rvalid_gap", {31'h0, rvalid}, 32'h0);
      check("b2b_stall_idle", {31'h0, stall}, 32'h1);
      @(negedge clk);
      re = 1'b0;
      #1;
      check("b2b_rvalid_2", {31'h0, rvalid}, 32'h1);
      @(negedge clk);

      // An ack while idle must not produce a response
      eth_ack = 1'b1; eth_rdata = 32'h1111_2222;
      repeat (2) @(negedge clk);
      eth_ack = 1'b0;
      #1;
      check("idle_ack_eth_req", {31'h0, eth_req}, 32'h0);

`ifdef LOAD_SELECT_TIMEOUT_EN
      eth_load(3, 32'hCAFE_0001);
      eth_load(1, 32'h0000_BEEF);
      eth_load(TO, 32'hCAFE_0002);
      @(negedge clk);
      re = 1'b1; addr = 32'h0000_0820;
      sb_q.push_back('{data: ERR_DATA, err: 1'b1});
      for (int i = 1; i <= TO; i++) begin
         @(negedge clk);
         re = 1'b0;
         #1;
         check("to_eth_req_wait", {31'h0, eth_req}, 32'h1);
         check("to_rvalid_wait", {31'h0, rvalid}, 32'h0);
      end
      @(negedge clk);
      #1;
      check("to_rvalid", {31'h0, rvalid}, 32'h1);
      check("to_err", {31'h0, err}, 32'h1);
      check("to_eth_req_low", {31'h0, eth_req}, 32'h0);
      @(negedge clk);
`else
      eth_load(5, 32'hCAFE_0001);
      eth_load(1, 32'h0000_BEEF);
      eth_load(20, 32'hCAFE_0002);
`endif

      // Reset during the Ethernet wait discards the load and ignores a later ack
      @(negedge clk);
      re = 1'b1; addr = 32'h0000_0820;
      @(negedge clk);
      re = 1'b0;
      #1;
      check("mid_eth_req_before", {31'h0, eth_req}, 32'h1);
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("mid_eth_req_after", {31'h0, eth_req}, 32'h0);
      check("mid_rvalid_after", {31'h0, rvalid}, 32'h0);
      check("mid_stall_after", {31'h0, stall}, 32'h0);
      @(negedge clk);
      eth_ack = 1'b1; eth_rdata = 32'h3333_4444;
      @(negedge clk);
      eth_ack = 1'b0;
      #1;
      check("mid_late_ack_rvalid", {31'h0, rvalid}, 32'h0);
      check("mid_late_ack_eth_req", {31'h0, eth_req}, 32'h0);
      sw_rdata = 16'h0042;
      load_fast(32'h0000_0808, 32'h0000_0042, 1'b0);

      repeat (3) @(negedge clk);
      check("sb_empty", sb_q.size(), 32'h0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/load_select.md
# load_select

Load-path read selector for the pipelined CPU's memory stage, the read-side counterpart of the store write-enable decoder. It decodes a load address, returns data from DMEM or a memory-mapped peripheral (switches, timer, Ethernet receive port), and stalls the pipeline until the data is ready. Results are registered, so slow peripherals and the synchronous DMEM share one response handshake.

## Interface
- TIMEOUT_CYCLES, 255: maximum cycles to wait for eth_ack; only used with the timeout feature.
- ERR_DATA, 32'h0000_0000: value returned on an unmapped or timed-out read.
- clk  in  1  system clock; all logic is on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- re  in  1  load request from the MEM stage.
- addr  in  32  load byte address.
- dmem_rdata  in  32  DMEM read data, valid one cycle after the address.
- sw_rdata  in  16  switch inputs; zero-extended on return.
- timer_rdata  in  32  timer count.
- eth_req  out  1  read request to the Ethernet receive port.
- eth_ack  in  1  Ethernet data valid; qualifies eth_rdata.
- eth_rdata  in  32  Ethernet receive data.
- rdata  out  32  load result; registered and held until the next response.
- rvalid  out  1  one-cycle pulse: rdata is updated this cycle.
- stall  out  1  freezes the pipeline while a load is outstanding.
- err  out  1  one-cycle pulse with rvalid on an unmapped or timed-out read.

## Operation
- Address decode:
  - addr[11]=0 → DMEM.
  - addr[11:0] 0x808 → switches.
  - 0x810 → timer.
  - 0x820 → Ethernet receive.
  - Any other address with addr[11]=1 → unmapped.
- States:
  - IDLE: wait for a request.
  - DMEM_WAIT: wait for the DMEM read.
  - ETH_WAIT: wait for the Ethernet port.
  - RESP: present the result.
- IDLE, re=1: latch the decode result.
  - DMEM → DMEM_WAIT.
  - Ethernet → ETH_WAIT.
  - Switches, timer or unmapped → capture the value now (unmapped returns ERR_DATA and sets err) → RESP.
- DMEM_WAIT: capture dmem_rdata → RESP.
- ETH_WAIT: hold eth_req=1.
  - eth_ack=1: capture eth_rdata, drop eth_req → RESP.
- RESP: rvalid=1 for this cycle only, then → IDLE unconditionally.
- re is sampled only in IDLE; it is ignored in every other state.
- eth_ack outside ETH_WAIT is ignored.
- stall = (state==IDLE & re) | state==DMEM_WAIT | state==ETH_WAIT. It is low in RESP so the load retires.

## Timing
- Reset values: all outputs 0, state IDLE, timeout counter 0. rdata resets to 0, not ERR_DATA.
- Request accepted in IDLE at cycle T. Cycle of the rvalid pulse by target:
  - Switches, timer, unmapped: T+1.
  - DMEM: T+2.
  - Ethernet: ack cycle + 1.
- eth_req rises at T+1 and is low in the cycle after the ack.
- The earliest next request is the cycle after RESP.
- rst_n low in any state returns to IDLE next edge: eth_req drops, no rvalid is produced, and the in-flight load is discarded.

## Configuration
- LOAD_SELECT_TIMEOUT_EN defined:
  - A counter runs in ETH_WAIT.
  - After TIMEOUT_CYCLES cycles without ack: return ERR_DATA, err=1, drop eth_req → RESP.
  - If ack and expiry occur in the same cycle, ack wins.
  - The counter clears on entry to ETH_WAIT.
- Undefined: no counter; ETH_WAIT waits indefinitely for eth_ack, and err is driven only by unmapped reads.

## Structure
- load_select_pkg holds:
  - Address constants: ADDR_SW=12'h808, ADDR_TIMER=12'h810, ADDR_ETH_RX=12'h820.
  - The state enum.
  - The decode-target enum (DMEM, SW, TIMER, ETH, UNMAPPED).
- Store-side decode constants (0x804 and others) move into the same package so both paths share one address map.
- One sub-module, ls_timeout_ctr: a clear/enable/expire counter, instantiated only under LOAD_SELECT_TIMEOUT_EN.

## Test plan
- Reset: hold rst_n=0 with re=1 → rdata=0, rvalid=0, stall=0, eth_req=0.
- DMEM load: re=1, addr=0x0000_0040, dmem_rdata=0x1234_5678 at T+1 → stall high at T and T+1; rvalid and rdata=0x1234_5678 at T+2.
- Switch load: addr=0x808, sw_rdata=0xA5A5 → rdata=0x0000_A5A5 and rvalid at T+1; stall high only at T.
- Ethernet load: addr=0x820, ack after 5 cycles with eth_rdata=0xCAFE_0001 → eth_req high T+1..T+5; rvalid at T+6 with that data; err=0.
- Unmapped and timeout:
  - addr=0x8FC → rdata=ERR_DATA, err=1 at T+1.
  - With LOAD_SELECT_TIMEOUT_EN, TIMEOUT_CYCLES=4 and no ack → err=1, rdata=ERR_DATA, eth_req low after the timeout.
  - Ack on the expiry cycle → data returned, err=0.
- Reset mid-Ethernet-wait: rst_n=0 for one cycle during ETH_WAIT → IDLE; eth_req low; no rvalid; a later ack is ignored.
